// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//
// Purpose
//   Merges two register-file write sources onto one registered write port:
//     * the in-order pipeline writeback (single-cycle, can be stalled), and
//     * a multi-cycle unit (MDU) whose results are buffered in a 2-entry FIFO.
//   The pipeline normally wins. A buffered MDU result that has waited
//   STARVE_LIMIT cycles is force-granted and the pipeline is stalled for
//   that one cycle.
//
// Parameters
//   STARVE_LIMIT  cycles a buffered MDU result may wait before a forced grant
//                 (1..15)
//
// Ports
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   wb_valid    in   pipeline writeback request
//   wb_rdc      in   pipeline destination register (0 = no write)
//   wb_data     in   pipeline writeback data
//   pipe_stall  out  pipeline request not accepted this cycle; hold inputs
//   mdu_valid   in   MDU result valid
//   mdu_ready   out  MDU result accepted when mdu_valid && mdu_ready
//   mdu_rdc     in   MDU destination register (0 = discarded)
//   mdu_data    in   MDU result data
//   RF_W        out  registered register-file write enable
//   Rdc         out  registered register-file write address
//   Rd          out  registered register-file write data
//   pend_mask   out  bit r set while a write to r is buffered or being written
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rdc,
   input  logic [31:0] wb_data,
   output logic        pipe_stall,
   input  logic        mdu_valid,
   output logic        mdu_ready,
   input  logic [4:0]  mdu_rdc,
   input  logic [31:0] mdu_data,
   output logic        RF_W,
   output logic [4:0]  Rdc,
   output logic [31:0] Rd,
   output logic [31:0] pend_mask
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   // Arbitration outcome for the current cycle.
   typedef enum logic [1:0] {
      GNT_IDLE  = 2'd0,
      GNT_PIPE  = 2'd1,
      GNT_MDU   = 2'd2,
      GNT_FORCE = 2'd3
   } grant_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [4:0]  fifo_rdc_reg  [2];
   logic [31:0] fifo_data_reg [2];
   logic        head_reg;
   logic        tail_reg;
   logic [1:0]  count_reg;
   logic [1:0]  count_next;
   logic [3:0]  starve_reg;
   logic [3:0]  starve_next;

   logic        rf_w_reg;
   logic [4:0]  rdc_reg;
   logic [31:0] rd_reg;
   logic        rf_w_next;
   logic [4:0]  rdc_next;
   logic [31:0] rd_next;

   // ------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------
   grant_t      grant;
   logic        pipe_req;
   logic        head_avail;
   logic        head_grant;
   logic        push;
   logic        pop;
   logic [4:0]  head_rdc;
   logic [31:0] head_data;
   logic [1:0]  entry_valid;

   // A destination of r0 is never a real write.
   assign pipe_req   = wb_valid && (wb_rdc != 5'd0);
   assign head_avail = (count_reg != 2'd0);
   assign head_rdc   = fifo_rdc_reg[head_reg];
   assign head_data  = fifo_data_reg[head_reg];

   // No bypass path: a full FIFO simply back-pressures the MDU.
   assign mdu_ready  = (count_reg != 2'd2) && !rst;

   // Handshakes to r0 complete (ready is high) but are dropped here, so the
   // FIFO only ever holds entries with a non-zero destination.
   assign push       = mdu_valid && mdu_ready && (mdu_rdc != 5'd0);

   always_comb begin
      grant = GNT_IDLE;
      if (head_avail && (starve_reg == LIMIT)) begin
         grant = GNT_FORCE;
      end else if (pipe_req) begin
         grant = GNT_PIPE;
      end else if (head_avail) begin
         grant = GNT_MDU;
      end
   end

   assign head_grant = (grant == GNT_FORCE) || (grant == GNT_MDU);
   assign pop        = head_grant;

   // The pipeline is only ever held back by a forced MDU grant.
   assign pipe_stall = (grant == GNT_FORCE) && pipe_req && !rst;

   // Registered write-port contents for the next cycle.
   always_comb begin
      rf_w_next = 1'b0;
      rdc_next  = 5'd0;
      rd_next   = 32'd0;
      case (grant)
         GNT_PIPE: begin
            rf_w_next = 1'b1;
            rdc_next  = wb_rdc;
            rd_next   = wb_data;
         end
         GNT_MDU, GNT_FORCE: begin
            rf_w_next = 1'b1;
            rdc_next  = head_rdc;
            rd_next   = head_data;
         end
         default: begin
         end
      endcase
   end

   // Occupancy: push and pop on the same edge leave the count unchanged,
   // which keeps a count of 1 with the new entry behind the old one.
   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 2'd1;
         2'b01:   count_next = count_reg - 2'd1;
         default: count_next = count_reg;
      endcase
   end

   // Waiting time of the current head. Once it reaches LIMIT the head is
   // force-granted, so the saturating branch is only a safety net.
   always_comb begin
      starve_next = starve_reg;
      if ((count_reg == 2'd0) || head_grant) begin
         starve_next = 4'd0;
      end else if (starve_reg != LIMIT) begin
         starve_next = starve_reg + 4'd1;
      end
   end

   // ------------------------------------------------------------------
   // Sequential logic
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         head_reg   <= 1'b0;
         tail_reg   <= 1'b0;
         count_reg  <= 2'd0;
         starve_reg <= 4'd0;
         rf_w_reg   <= 1'b0;
         rdc_reg    <= 5'd0;
         rd_reg     <= 32'd0;
      end else begin
         if (push) begin
            tail_reg <= ~tail_reg;
         end
         if (pop) begin
            head_reg <= ~head_reg;
         end
         count_reg  <= count_next;
         starve_reg <= starve_next;
         rf_w_reg   <= rf_w_next;
         rdc_reg    <= rdc_next;
         rd_reg     <= rd_next;
      end
   end

   // FIFO storage carries no reset; entries are qualified by count/head.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rdc_reg[tail_reg]  <= mdu_rdc;
         fifo_data_reg[tail_reg] <= mdu_data;
      end
   end

   assign RF_W = rf_w_reg;
   assign Rdc  = rdc_reg;
   assign Rd   = rd_reg;

   // ------------------------------------------------------------------
   // Pending-write scoreboard
   // ------------------------------------------------------------------
   // Entry i is live when the FIFO is full, or when it holds one entry and
   // that entry is the head.
   for (genvar gi = 0; gi < 2; gi++) begin : g_entry_valid
      assign entry_valid[gi] = (count_reg == 2'd2) ||
                               ((count_reg == 2'd1) && (head_reg == 1'(gi)));
   end

   // r0 is never written, so its bit is tied low.
   assign pend_mask[0] = 1'b0;

   for (genvar gi = 1; gi < 32; gi++) begin : g_pend_mask
      assign pend_mask[gi] =
         (entry_valid[0] && (fifo_rdc_reg[0] == 5'(gi))) ||
         (entry_valid[1] && (fifo_rdc_reg[1] == 5'(gi))) ||
         (rf_w_reg       && (rdc_reg         == 5'(gi)));
   end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, which is the number of consecutive cycles a buffered MDU result may wait before it forces a grant (range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port wb_valid, input, 1 bit: pipeline writeback request this cycle.
REQ-005 SHALL have port wb_rdc, input, 5 bits: pipeline destination register.
REQ-006 SHALL have port wb_data, input, 32 bits: pipeline writeback data.
REQ-007 SHALL have port pipe_stall, output, 1 bit: pipeline WB not accepted this cycle, so the pipeline must hold wb_valid, wb_rdc and wb_data.
REQ-008 SHALL have port mdu_valid, input, 1 bit: multi-cycle unit result valid.
REQ-009 SHALL have port mdu_ready, output, 1 bit: the MDU result is accepted when valid and ready are both high.
REQ-010 SHALL have port mdu_rdc, input, 5 bits: MDU destination register.
REQ-011 SHALL have port mdu_data, input, 32 bits: MDU result data.
REQ-012 SHALL have port RF_W, output, 1 bit: register-file write enable, registered.
REQ-013 SHALL have port Rdc, output, 5 bits: register-file write address, registered.
REQ-014 SHALL have port Rd, output, 32 bits: register-file write data, registered.
REQ-015 SHALL have port pend_mask, output, 32 bits: bit r is high while a write to register r is buffered or in the output stage.

Function
REQ-016 SHALL contain a 2-entry FIFO for MDU results (rdc, data), with a 2-bit count and head/tail pointers that wrap modulo 2.
REQ-017 SHALL drive mdu_ready = (count != 2) && !rst, combinationally; no bypass of a full FIFO.
REQ-018 SHALL push on mdu_valid && mdu_ready && mdu_rdc != 0; an accepted handshake with mdu_rdc == 0 SHALL be discarded.
REQ-019 SHALL treat wb_valid with wb_rdc == 0 as no request; pipe_stall is 0 in that case.
REQ-020 SHALL select a grant combinationally, by priority:
  (a) FORCE: count != 0 and starve_cnt == STARVE_LIMIT, so the FIFO head is granted and pipe_stall = wb_valid && wb_rdc != 0;
  (b) PIPE: wb_valid && wb_rdc != 0, so the pipeline is granted;
  (c) MDU: count != 0, so the FIFO head is granted;
  (d) IDLE.
REQ-021 SHALL leave pipe_stall at 0 in every case except FORCE.
REQ-022 SHALL pop the FIFO head on the same edge that an MDU grant registers.
REQ-023 SHALL allow push and pop on the same edge when count == 1; count stays 1 and order is preserved.
REQ-024 SHALL maintain starve_cnt, 4 bits:
  - cleared when count == 0 or the head is granted;
  - otherwise incremented, saturating at STARVE_LIMIT.
REQ-025 SHALL register the grant at the edge as RF_W <= 1, Rdc <= granted rdc, Rd <= granted data; on IDLE it registers RF_W <= 0, Rdc <= 0, Rd <= 0.
REQ-026 SHALL give pipeline latency of one edge: a request granted in cycle t appears on RF_W/Rdc/Rd after edge t.
REQ-027 SHALL give MDU minimum latency of two edges: pushed at edge t, eligible in cycle t+1, and visible after edge t+1.
REQ-028 SHALL drive pend_mask as the OR of one-hot(rdc) over valid FIFO entries and one-hot(Rdc) when RF_W == 1; bit 0 is always 0.
REQ-029 SHALL keep MDU writes in FIFO order; duplicate destinations are allowed, and the later write lands last.
REQ-030 SHALL never assert RF_W with Rdc == 0.

Reset
REQ-031 SHALL, while rst is high at an edge, set FIFO count, pointers and starve_cnt to 0, and RF_W = 0, Rdc = 0, Rd = 0.
REQ-032 SHALL force pipe_stall = 0 and mdu_ready = 0 while rst is high.
REQ-033 SHALL discard buffered MDU entries on reset mid-operation, with no write issued for them.
REQ-034 SHALL make pend_mask = 0 the cycle after reset.

Verification
REQ-035 SHALL cover: pipeline only, wb_valid=1, wb_rdc=5, wb_data=0xDEADBEEF -> after 1 edge RF_W=1, Rdc=5, Rd=0xDEADBEEF, pipe_stall=0.
REQ-036 SHALL cover: MDU only into an empty FIFO, rdc=7, data=0x12 -> mdu_ready=1; after 2 edges RF_W=1, Rdc=7; pend_mask[7]=1 from edge 1 until after the output cycle.
REQ-037 SHALL cover: pipeline busy every cycle and MDU pushing rdc=3 then rdc=4, STARVE_LIMIT=4 -> mdu_ready=0 after two pushes; rdc=3 is force-granted with pipe_stall=1 in exactly one cycle; rdc=4 follows in order.
REQ-038 SHALL cover: rdc=0 from both sources -> no RF_W pulse, FIFO count unchanged, pipe_stall=0.
REQ-039 SHALL cover: FIFO at count=1 with a simultaneous push and MDU grant -> count stays 1, and the old entry is written before the new one.
REQ-040 SHALL cover: rst asserted with count=2 -> next cycle RF_W=0, pend_mask=0, mdu_ready=1 once rst is low, and no stale writes appear.
